// File: rtl/spi_slave_transmitter_if.sv
// Response handshake and SPI pin bundle between the SD-card SPI controller and
// spi_slave_transmitter; the transmitter uses the slave modport.
interface spi_slave_transmitter_if #(
    parameter int MAX_BYTES = 5
);
    logic                     io_SpiClk;
    logic                     io_CS;
    logic                     io_ResponseValid;
    logic                     io_ResponseReady;
    logic [8*MAX_BYTES-1:0]   io_ResponseData;
    logic [2:0]               io_ResponseLength;
    logic                     io_CardBusy;
    logic                     io_DO;
    logic                     io_Sending;
    logic                     io_Done;

    modport master (
        output io_SpiClk, io_CS, io_ResponseValid, io_ResponseData,
               io_ResponseLength, io_CardBusy,
        input  io_ResponseReady, io_DO, io_Sending, io_Done
    );

    modport slave (
        input  io_SpiClk, io_CS, io_ResponseValid, io_ResponseData,
               io_ResponseLength, io_CardBusy,
        output io_ResponseReady, io_DO, io_Sending, io_Done
    );
endinterface

// File: rtl/spi_slave_transmitter.sv
// SD-card SPI response transmitter: Ncr 0xFF gap, then the response MSB-first on DO.
// Optional macro SPI_TX_BUSY_EN adds a BUSY state that drives zero bytes while the card is busy.
module spi_slave_transmitter #(
    parameter int NCR_BYTES = 1,
    parameter int MAX_BYTES = 5
) (
    input logic              clock,
    input logic              reset,
    spi_slave_transmitter_if.slave bus
);
    localparam int         W        = 8 * MAX_BYTES;
    localparam logic [6:0] NCR_BITS = 7'(8 * NCR_BYTES);
    localparam logic [3:0] MAX_LEN  = 4'(MAX_BYTES);

`ifdef SPI_TX_BUSY_EN
    typedef enum logic [1:0] {IDLE, NCR, SEND, BUSY} state_t;
`else
    typedef enum logic [1:0] {IDLE, NCR, SEND} state_t;
    logic unused_card_busy;
    assign unused_card_busy = bus.io_CardBusy;
`endif

    state_t         state_q, state_d;
    logic           prev_clk_q, prev_clk_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [3:0]     byte_q, byte_d;
    logic [W-1:0]   shift_q, shift_d;
    logic           do_q, do_d;
    logic           done_q, done_d;

    logic           fe;
    logic           ready;
    logic           accept;
    logic           step;
    logic           finish;
    logic [2:0]     bit_idx;
    logic [3:0]     len_clamped;

    assign fe      = prev_clk_q & ~bus.io_SpiClk;
    assign ready   = (state_q == IDLE) && !done_q;
    assign accept  = bus.io_ResponseValid & ready & ~bus.io_CS;
    // The fe that leaves NCR sends the first bit of byte 0, so it acts as bit index 0.
    assign bit_idx = (state_q == SEND) ? cnt_q[2:0] : 3'd0;

    always_comb begin
        len_clamped = {1'b0, bus.io_ResponseLength};
        if (len_clamped == 4'd0) begin
            len_clamped = 4'd1;
        end else if (len_clamped > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_clk_d = bus.io_SpiClk;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        do_d       = do_q;
        done_d     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;

        if (state_q != IDLE && bus.io_CS) begin
            state_d = IDLE;
            do_d    = 1'b1;
            cnt_d   = '0;
            byte_d  = '0;
            shift_d = '1;
        end else begin
            case (state_q)
                IDLE: begin
                    do_d = 1'b1;
                    if (accept) begin
                        state_d = NCR;
                        cnt_d   = '0;
                        byte_d  = len_clamped;
                        shift_d = bus.io_ResponseData;
                    end
                end
                NCR: begin
                    if (fe) begin
                        if (cnt_q == NCR_BITS) begin
                            state_d = SEND;
                            step    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                SEND: begin
                    if (fe) begin
                        if (byte_q == 4'd0) begin
`ifdef SPI_TX_BUSY_EN
                            if (bus.io_CardBusy) begin
                                state_d = BUSY;
                                do_d    = 1'b0;
                                cnt_d   = 7'd1;
                                shift_d = '1;
                            end else begin
                                finish = 1'b1;
                            end
`else
                            finish = 1'b1;
`endif
                        end else begin
                            step = 1'b1;
                        end
                    end
                end
`ifdef SPI_TX_BUSY_EN
                BUSY: begin
                    // Busy is only released on a byte boundary so the host sees whole zero bytes.
                    if (fe) begin
                        if (cnt_q[2:0] == 3'd0 && !bus.io_CardBusy) begin
                            finish = 1'b1;
                        end else begin
                            do_d  = 1'b0;
                            cnt_d = {4'd0, cnt_q[2:0] + 3'd1};
                        end
                    end
                end
`endif
                default: state_d = IDLE;
            endcase

            if (step) begin
                do_d    = shift_q[W-1];
                shift_d = {shift_q[W-2:0], 1'b1};
                if (bit_idx == 3'd7) begin
                    cnt_d  = '0;
                    byte_d = byte_q - 4'd1;
                end else begin
                    cnt_d = {4'd0, bit_idx + 3'd1};
                end
            end

            if (finish) begin
                state_d = IDLE;
                do_d    = 1'b1;
                done_d  = 1'b1;
                cnt_d   = '0;
                shift_d = '1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_clk_q <= 1'b0;
            cnt_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '1;
            do_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_clk_q <= prev_clk_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            do_q       <= do_d;
            done_q     <= done_d;
        end
    end

    assign bus.io_DO            = do_q;
    assign bus.io_Done          = done_q;
    assign bus.io_ResponseReady = ready;
    assign bus.io_Sending       = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_transmitter.sv
// Bench for spi_slave_transmitter: two instances (NCR_BYTES=1 and 2) share one stimulus
// and are compared every cycle against a fill/data/done model indexed by falling-edge count.
module tb_spi_slave_transmitter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_clk = 1'b0;
    logic        cs = 1'b1;
    logic        valid = 1'b0;
    logic        card_busy = 1'b0;
    logic [39:0] data = '1;
    logic [2:0]  len = 3'd1;

    always #5 clock = ~clock;

    spi_slave_transmitter_if #(.MAX_BYTES(5)) bus0 ();
    spi_slave_transmitter_if #(.MAX_BYTES(5)) bus1 ();

    assign bus0.io_SpiClk = spi_clk;
    assign bus0.io_CS = cs;
    assign bus0.io_ResponseValid = valid;
    assign bus0.io_ResponseData = data;
    assign bus0.io_ResponseLength = len;
    assign bus0.io_CardBusy = card_busy;
    assign bus1.io_SpiClk = spi_clk;
    assign bus1.io_CS = cs;
    assign bus1.io_ResponseValid = valid;
    assign bus1.io_ResponseData = data;
    assign bus1.io_ResponseLength = len;
    assign bus1.io_CardBusy = card_busy;

    spi_slave_transmitter #(.NCR_BYTES(1), .MAX_BYTES(5)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave));
    spi_slave_transmitter #(.NCR_BYTES(2), .MAX_BYTES(5)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));

    logic [1:0] o_do, o_done, o_ready, o_send;
    assign o_do[0] = bus0.io_DO;
    assign o_do[1] = bus1.io_DO;
    assign o_done[0] = bus0.io_Done;
    assign o_done[1] = bus1.io_Done;
    assign o_ready[0] = bus0.io_ResponseReady;
    assign o_ready[1] = bus1.io_ResponseReady;
    assign o_send[0] = bus0.io_Sending;
    assign o_send[1] = bus1.io_Sending;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // SPI clock: 4 system clocks high, 4 low, when enabled.
    bit spi_en = 1'b0;
    int ph = 0;
    always @(negedge clock) begin
        if (spi_en) begin
            ph = (ph + 1) % 8;
            spi_clk = (ph < 4);
        end
    end

    // Model: after accept, fe k drives 1 for k<=8*N, response bit k-8N-1 (MSB first) up to
    // 8*(N+len), then DO=1 with Done on the next fe.
    bit          m_started = 1'b0;
    bit          m_prev = 1'b0;
    bit          m_active [2] = '{0, 0};
    bit          m_busy_ph [2] = '{0, 0};
    bit          m_do [2] = '{1, 1};
    bit          m_done [2] = '{0, 0};
    bit          m_ready [2] = '{1, 1};
    bit          m_tick [2] = '{0, 0};
    int          m_fe [2];
    int          m_bz [2];
    int          m_len [2];
    logic [39:0] m_resp [2];

    always @(posedge clock) begin
        bit fe;
        int k, nb, nr;
        fe = m_prev && !spi_clk;
        m_prev = reset ? 1'b0 : spi_clk;
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 1'b0;
            m_done[i] = 1'b0;
            if (reset) begin
                m_active[i] = 1'b0;
                m_busy_ph[i] = 1'b0;
                m_do[i] = 1'b1;
            end else if (!m_active[i]) begin
                m_do[i] = 1'b1;
                if (valid && m_ready[i] && !cs) begin
                    m_active[i] = 1'b1;
                    m_busy_ph[i] = 1'b0;
                    m_fe[i] = 0;
                    m_resp[i] = data;
                    m_len[i] = (len == 3'd0) ? 1 : ((int'(len) > 5) ? 5 : int'(len));
                end
            end else if (cs) begin
                m_active[i] = 1'b0;
                m_busy_ph[i] = 1'b0;
                m_do[i] = 1'b1;
            end else if (fe) begin
                m_tick[i] = 1'b1;
                m_fe[i]++;
                k = m_fe[i];
                nb = 8 * (i + 1);
                nr = 8 * m_len[i];
                if (m_busy_ph[i]) begin
                    if (m_bz[i] % 8 == 0 && !card_busy) begin
                        m_active[i] = 1'b0;
                        m_busy_ph[i] = 1'b0;
                        m_do[i] = 1'b1;
                        m_done[i] = 1'b1;
                    end else begin
                        m_bz[i]++;
                        m_do[i] = 1'b0;
                    end
                end else if (k <= nb) begin
                    m_do[i] = 1'b1;
                end else if (k <= nb + nr) begin
                    m_do[i] = m_resp[i][39 - (k - nb - 1)];
                end else begin
`ifdef SPI_TX_BUSY_EN
                    if (card_busy) begin
                        m_busy_ph[i] = 1'b1;
                        m_bz[i] = 1;
                        m_do[i] = 1'b0;
                    end else begin
                        m_active[i] = 1'b0;
                        m_do[i] = 1'b1;
                        m_done[i] = 1'b1;
                    end
`else
                    m_active[i] = 1'b0;
                    m_do[i] = 1'b1;
                    m_done[i] = 1'b1;
`endif
                end
            end
            m_ready[i] = !m_active[i] && !m_done[i];
        end
        m_started = 1'b1;
    end

    // Per-cycle compare, plus capture of DUT DO after every counted fe for literal checks.
    logic [127:0] cap [2];
    int cap_n [2] = '{0, 0};
    int done_at [2] = '{0, 0};

    always @(negedge clock) begin
        if (m_started) begin
            for (int i = 0; i < 2; i++) begin
                check_output($sformatf("inst%0d DO", i), o_do[i], m_do[i]);
                check_output($sformatf("inst%0d Done", i), o_done[i], m_done[i]);
                check_output($sformatf("inst%0d Ready", i), o_ready[i], m_ready[i]);
                check_output($sformatf("inst%0d Sending", i), o_send[i], m_active[i]);
                if (m_tick[i]) begin
                    cap[i] = {cap[i][126:0], o_do[i]};
                    cap_n[i]++;
                    if (o_done[i] === 1'b1) done_at[i] = cap_n[i];
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_cap(input int i);
        cap[i] = '0;
        cap_n[i] = 0;
        done_at[i] = 0;
    endtask

    task automatic apply_stimulus(input logic [39:0] d, input logic [2:0] l);
        clear_cap(0);
        clear_cap(1);
        valid = 1'b1;
        data = d;
        len = l;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_cap(input int i, input int n);
        int c = 0;
        while (cap_n[i] < n && c < 2000) begin
            tick();
            c++;
        end
        checks++;
        if (cap_n[i] < n) begin
            errors++;
            $display("[TB] FAIL inst%0d wait for fe %0d: got %0d fe, expected %0d", i, n, cap_n[i], n);
        end
    endtask

    task automatic wait_done(input int i);
        int c = 0;
        while (done_at[i] == 0 && c < 2000) begin
            tick();
            c++;
        end
        checks++;
        if (done_at[i] == 0) begin
            errors++;
            $display("[TB] FAIL inst%0d Done timeout: got no pulse, expected one within 2000 cycles", i);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((m_active[0] || m_active[1] || m_done[0] || m_done[1]) && c < 2000) begin
            tick();
            c++;
        end
        repeat (3) tick();
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("%s inst%0d DO", tag, i), o_do[i], 1'b1);
            check_output($sformatf("%s inst%0d Ready", tag, i), o_ready[i], 1'b1);
            check_output($sformatf("%s inst%0d Sending", tag, i), o_send[i], 1'b0);
            check_output($sformatf("%s inst%0d Done", tag, i), o_done[i], 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 2000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        cs = 1'b0;
        spi_en = 1'b1;
        repeat (4) tick();

        // R1 0x01
        apply_stimulus(40'h01_0000_0000, 3'd1);
        check_output("r1 ready low after accept", o_ready[0], 1'b0);
        wait_done(0);
        wait_done(1);
        check_output("r1 n1 bits", cap[0], {8'hFF, 8'h01, 1'b1});
        check_output("r1 n1 done fe", done_at[0], 17);
        check_output("r1 n2 bits", cap[1], {16'hFFFF, 8'h01, 1'b1});
        check_output("r1 n2 done fe", done_at[1], 25);
        wait_idle();

        // R7 0x01000001AA, 5 bytes
        apply_stimulus(40'h01_0000_01AA, 3'd5);
        wait_done(0);
        wait_done(1);
        check_output("r7 n2 bits", cap[1], {16'hFFFF, 40'h01_0000_01AA, 1'b1});
        check_output("r7 n2 done fe", done_at[1], 57);
        check_output("r7 n1 bits", cap[0], {8'hFF, 40'h01_0000_01AA, 1'b1});
        check_output("r7 n1 done fe", done_at[0], 49);
        wait_idle();

        // Abort by CS after fe 12, then a normal transfer
        apply_stimulus(40'h01_0000_0000, 3'd1);
        wait_cap(0, 12);
        cs = 1'b1;
        tick();
        check_reset_values("abort");
        repeat (20) tick();
        check_output("abort no done", done_at[0], 0);
        cs = 1'b0;
        repeat (2) tick();
        apply_stimulus(40'h01_0000_0000, 3'd1);
        wait_done(0);
        check_output("after abort bits", cap[0], {8'hFF, 8'h01, 1'b1});
        check_output("after abort done fe", done_at[0], 17);
        wait_idle();

        // Back-to-back: valid raised in the Done cycle, accepted one cycle later
        apply_stimulus(40'h01_0000_0000, 3'd1);
        wait_done(0);
        clear_cap(0);
        valid = 1'b1;
        data = 40'h00_0000_0000;
        len = 3'd1;
        tick();
        tick();
        valid = 1'b0;
        check_output("b2b accepted", o_send[0], 1'b1);
        wait_done(0);
        check_output("b2b bits", cap[0], {8'hFF, 8'h00, 1'b1});
        check_output("b2b done fe", done_at[0], 17);
        wait_done(1);
        check_output("b2b n2 first done fe", done_at[1], 25);
        wait_idle();

        // Length clamping
        apply_stimulus(40'hA5_0000_0000, 3'd0);
        wait_done(0);
        check_output("len0 bits", cap[0], {8'hFF, 8'hA5, 1'b1});
        check_output("len0 done fe", done_at[0], 17);
        wait_idle();
        apply_stimulus(40'h01_0203_0405, 3'd7);
        wait_done(0);
        wait_done(1);
        check_output("len7 n1 done fe", done_at[0], 49);
        check_output("len7 n2 bits", cap[1], {16'hFFFF, 40'h01_0203_0405, 1'b1});
        check_output("len7 n2 done fe", done_at[1], 57);
        wait_idle();

        // Accept in the same cycle as an fe
        spi_en = 1'b0;
        spi_clk = 1'b1;
        repeat (4) tick();
        clear_cap(0);
        clear_cap(1);
        spi_clk = 1'b0;
        valid = 1'b1;
        data = 40'h01_0000_0000;
        len = 3'd1;
        tick();
        valid = 1'b0;
        ph = 4;
        spi_en = 1'b1;
        wait_done(0);
        check_output("coincide bits", cap[0], {8'hFF, 8'h01, 1'b1});
        check_output("coincide done fe", done_at[0], 17);
        wait_done(1);
        check_output("coincide n2 done fe", done_at[1], 25);
        wait_idle();

        // Reset in the middle of SEND
        apply_stimulus(40'h01_0000_0000, 3'd1);
        wait_cap(0, 10);
        reset = 1'b1;
        tick();
        check_reset_values("mid reset");
        reset = 1'b0;
        wait_idle();

`ifdef SPI_TX_BUSY_EN
        // Card busy released during the third busy byte
        card_busy = 1'b1;
        apply_stimulus(40'h00_0000_0000, 3'd1);
        wait_cap(0, 35);
        card_busy = 1'b0;
        wait_done(0);
        check_output("busy bits", cap[0], {8'hFF, 8'h00, 24'h000000, 1'b1});
        check_output("busy done fe", done_at[0], 41);
        wait_done(1);
        wait_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
